// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider.
//   state_t      : FSM state encoding (IDLE / RUN / DONE)
//   count_width  : width of the iteration counter for a given operand width
//                  (must be able to hold the value WIDTH itself)
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational iteration of a restoring divider: trial-subtract the
// divisor from the shifted partial remainder and restore on underflow.
// Ports:
//   r_shifted [WIDTH:0]   partial remainder after the left shift
//   d         [WIDTH-1:0] divisor
//   r_next    [WIDTH:0]   new partial remainder (difference or restored)
//   q_bit                 quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   r_shifted,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   r_next,
    output logic             q_bit
);

    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH+1:0] borrow;

    assign d_ext     = {1'b0, d};
    assign borrow[0] = 1'b0;

    // Ripple-borrow subtractor, one full subtractor per bit.
    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
            assign diff[gi]       = r_shifted[gi] ^ d_ext[gi] ^ borrow[gi];
            assign borrow[gi + 1] = (~r_shifted[gi] & d_ext[gi])
                                  | (~(r_shifted[gi] ^ d_ext[gi]) & borrow[gi]);
        end
    endgenerate

    // The final borrow-out is the sign of the trial difference. Because the
    // partial remainder stays below the divisor, the shifted value is below
    // twice the divisor and this agrees with the MSB of the difference.
    assign q_bit  = ~borrow[WIDTH + 1];
    assign r_next = q_bit ? diff : r_shifted;

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request, accepted in IDLE or DONE
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high while iterating
//   done         one-cycle pulse, results valid from this cycle
//   quotient     result, held until a new result is produced
//   remainder    result, held until a new result is produced
//   div_by_zero  set with done when the captured divisor was 0
// ---------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int COUNT_W = count_width(WIDTH);

    state_t state_reg, state_next;

    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH-1:0]   d_reg;
    logic [WIDTH:0]     r_reg;
    logic [COUNT_W-1:0] count_reg;
    logic [WIDTH-1:0]   quotient_reg;
    logic [WIDTH-1:0]   remainder_reg;
    logic               dbz_reg;

    logic               accept;
    logic               zero_div;
    logic               last_iter;
    logic [WIDTH:0]     r_shifted;
    logic [WIDTH:0]     r_next;
    logic [WIDTH-1:0]   q_next;
    logic               q_bit;

    assign accept    = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign zero_div  = (divisor == '0);
    assign last_iter = (count_reg == COUNT_W'(1));

    // {R,Q} shifted left by one: the dividend MSB moves into the remainder.
    assign r_shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign q_next    = {q_reg[WIDTH-2:0], q_bit};

    div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .r_shifted (r_shifted),
        .d         (d_reg),
        .r_next    (r_next),
        .q_bit     (q_bit)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    // A zero divisor bypasses iteration entirely.
                    state_next = zero_div ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_next = zero_div ? S_DONE : S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            count_reg     <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (accept) begin
            q_reg     <= dividend;
            d_reg     <= divisor;
            r_reg     <= '0;
            count_reg <= COUNT_W'(WIDTH);
            dbz_reg   <= zero_div;
            if (zero_div) begin
                quotient_reg  <= '1;
                remainder_reg <= dividend;
            end
        end else if (state_reg == S_RUN) begin
            q_reg     <= q_next;
            r_reg     <= r_next;
            count_reg <= count_reg - COUNT_W'(1);
            if (last_iter) begin
                quotient_reg  <= q_next;
                remainder_reg <= r_next[WIDTH-1:0];
            end
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- Behavioural reference model ----------------
    // Tracks the protocol in terms of "operation in flight, cycles left" and
    // computes results with plain / and %.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [W-1:0] m_pq = '0;
    logic [W-1:0] m_pr = '0;
    int           m_left = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
            m_left <= 0;
        end else if (!m_busy && start) begin
            if (divisor == 0) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_dbz  <= 1'b1;
                m_q    <= '1;
                m_r    <= dividend;
            end else begin
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_dbz  <= 1'b0;
                m_left <= W;
                m_pq   <= dividend / divisor;
                m_pr   <= dividend % divisor;
            end
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_q    <= m_pq;
                m_r    <= m_pr;
            end
            m_left <= m_left - 1;
        end else begin
            m_done <= 1'b0;
        end
    end

    // ---------------- Per-cycle comparison ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("div_by_zero", div_by_zero, m_dbz);
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("busy_done_excl", busy & done, 0);
        end
    end

    // Called at the first negedge after an accepting edge (n = 1 there).
    task automatic wait_done(output int n, output bit seen_busy);
        n = 1;
        seen_busy = busy;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
            if (busy) seen_busy = 1'b1;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    // One operation with optional literal expectations (exp_q < 0 skips them).
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input int exp_q, input int exp_r, input string tag);
        int n;
        bit seen_busy;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, seen_busy);
        if (exp_q >= 0 && done) begin
            chk({tag, "_q"}, quotient, exp_q);
            chk({tag, "_r"}, remainder, exp_r);
            chk({tag, "_dbz"}, div_by_zero, (b == 0) ? 1 : 0);
            chk({tag, "_model_q"}, m_q, exp_q);
            chk({tag, "_model_r"}, m_r, exp_r);
            chk({tag, "_latency"}, n, (b == 0) ? 1 : W + 1);
            if (b == 0) chk({tag, "_busy_seen"}, seen_busy, 0);
        end
        @(negedge clk);
        if (exp_q >= 0) begin
            chk({tag, "_done_drop"}, done, 0);
            chk({tag, "_hold_q"}, quotient, exp_q);
        end
        $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0d", tag, a, b, quotient, remainder, div_by_zero);
    endtask

    initial begin
        int n;
        bit seen_busy;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        op(4'd13, 4'd3, 4, 1, "basic");
        op(4'd15, 4'd1, 15, 0, "max_unit");
        op(4'd15, 4'd15, 1, 0, "max_max");
        op(4'd2, 4'd9, 0, 2, "small");
        op(4'd7, 4'd0, 15, 7, "div0");

        // Protocol: start held, operands change mid-RUN, back-to-back accept
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dividend = 4'd6;
        divisor  = 4'd3;
        wait_done(n, seen_busy);
        chk("proto1_q", quotient, 4);
        chk("proto1_r", remainder, 1);
        $display("op proto1: 9 / 2 -> q=%0d r=%0d", quotient, remainder);
        @(negedge clk);
        start = 1'b0;
        chk("proto_b2b_busy", busy, 1);
        chk("proto_b2b_done", done, 0);
        wait_done(n, seen_busy);
        chk("proto2_q", quotient, 2);
        chk("proto2_r", remainder, 0);
        chk("proto2_latency", n, W + 1);
        $display("op proto2: 6 / 3 -> q=%0d r=%0d", quotient, remainder);
        @(negedge clk);

        // Reset in the middle of an operation
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        $display("op midrst: aborted, outputs cleared");
        op(4'd10, 4'd4, 2, 2, "after_rst");

        // Exhaustive sweep, checked by the per-cycle model comparison
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op(W'(a), W'(b), -1, -1, "sweep");
            end
        end

        // Random traffic: random starts, operands, occasional reset
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rst_n    = ($urandom_range(0, 99) != 0);
            @(negedge clk);
            if (done) $display("op random: q=%0d r=%0d dbz=%0d", quotient, remainder, div_by_zero);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-operation counterpart of the lab's combinational array multiplier.
- Takes a WIDTH-bit dividend and divisor on a start pulse and produces quotient and remainder, one bit per clock.
- Uses a start/busy/done handshake so it can sit behind a simple controller or a testbench driver.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (legal values 2..16).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  request; sampled only when the divider is not busy.
- dividend  in  WIDTH  unsigned numerator, captured on the accepting edge.
- divisor  in  WIDTH  unsigned denominator, captured on the accepting edge.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; quotient and remainder are valid from this cycle.
- quotient  out  WIDTH  result; holds its value until the next accepted start.
- remainder  out  WIDTH  result; holds its value until the next accepted start.
- div_by_zero  out  1  set with done when the captured divisor is 0; cleared on the next accepted start.

Behaviour:
- Reset: one clock; synchronous, active-low. When rst_n=0 at an edge: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; internal registers = 0. Reset mid-operation aborts the operation and produces no done.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: one-cycle result-presentation state.
- Acceptance: start=1 at an edge while in IDLE or DONE.
  - Capture dividend into shift register Q and divisor into D.
  - Clear partial remainder R (WIDTH+1 bits).
  - Set count=WIDTH, clear div_by_zero, busy=1, go to RUN.
  - start in RUN is ignored; operands are not re-captured.
- Divide by zero: if the captured divisor is 0, skip RUN and go directly to DONE at the next edge with:
  - quotient = all ones;
  - remainder = dividend;
  - div_by_zero = 1, done = 1, busy = 0.
- RUN iteration (each edge):
  - Shift {R,Q} left by one.
  - Trial T = R_shifted - {0,D}.
  - If T is non-negative (MSB 0): R = T and Q[0] = 1. Otherwise R is restored (kept as shifted) and Q[0] = 0.
  - Decrement count.
- Completion: the edge that performs the WIDTH-th iteration also:
  - loads quotient = Q and remainder = R[WIDTH-1:0];
  - sets done=1, busy=0, state=DONE.
- Latency: if start is accepted at edge 0, done is high between edges WIDTH and WIDTH+1 (4 cycles at the default). The divide-by-zero case has a latency of 1 cycle.
- DONE: lasts exactly one cycle.
  - Without start: go to IDLE and deassert done. Outputs keep their values.
  - With start: accept the new operation (back-to-back); done drops and busy rises in the same edge.
- Invariant: busy and done are never high together.
- Width rule: the remainder is always < divisor, and dividend = quotient*divisor + remainder for divisor != 0. No overflow is possible for unsigned WIDTH/WIDTH division.

Decomposition:
- Shared package div_pkg:
  - state encoding constants S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10;
  - count width constant, clog2(WIDTH)+1.
- One natural combinational sub-module: div_step. It takes R_shifted and D, and returns the next R and the quotient bit. It contains the subtractor and restore mux, and is instantiated once inside seq_divider.

Test Plan:
- Basic division, WIDTH=4: dividend=13, divisor=3, start for 1 cycle -> busy for 4 cycles, then done pulse with quotient=4, remainder=1, div_by_zero=0.
- Maximum and unit operands: 15/1 -> quotient=15, remainder=0. 15/15 -> quotient=1, remainder=0. 2/9 -> quotient=0, remainder=2.
- Divide by zero: 7/0 -> done one cycle after start, quotient=15, remainder=7, div_by_zero=1, busy never high.
- Protocol: start held high with 9/2 and the operands changed to 6/3 mid-RUN -> result is quotient=4, remainder=1. The second start is ignored until DONE, then accepted back-to-back, giving quotient=2, remainder=0 four cycles later.
- Reset mid-operation: rst_n=0 at the 2nd RUN cycle -> all outputs 0 next edge, no done pulse. A subsequent 10/4 -> quotient=2, remainder=2.
- Exhaustive sweep over all 256 WIDTH=4 operand pairs: every result checked against the reference model, and busy/done never high together.
